// File: rtl/avm_integ_master.sv
`default_nettype none
// ============================================================================
// Module      : avm_integ_master
// Description : Avalon-MM master feeding the integrator register file. Buffers
//               streamed samples, converts clear requests into a control write,
//               and periodically reads the integrator result back.
// Revision    : 1.0 - initial release
// ============================================================================
module avm_integ_master #(
    parameter int         N         = 32,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] DATA_ADDR = 8'd0,
    parameter logic [7:0] CLR_ADDR  = 8'd1,
    parameter int         RB_EVERY  = 4
) (
    input  logic                       csi_clk,
    input  logic                       rsi_srst,
    input  logic                       asi_in_valid,
    output logic                       asi_in_ready,
    input  logic [N-1:0]               asi_in_data,
    input  logic                       coe_clear,
    output logic [7:0]                 avm_m0_address,
    output logic                       avm_m0_write,
    output logic [N-1:0]               avm_m0_writedata,
    output logic                       avm_m0_read,
    input  logic [N-1:0]               avm_m0_readdata,
    input  logic                       avm_m0_waitrequest,
    output logic [N-1:0]               coe_R,
    output logic                       coe_R_valid,
    output logic [$clog2(DEPTH):0]     coe_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_cw = (RB_EVERY < 2) ? 1 : $clog2(RB_EVERY);
    localparam logic [c_cw-1:0] c_rb_last = c_cw'((RB_EVERY == 0) ? 0 : RB_EVERY - 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_wr_data = 2'd1;
    localparam logic [1:0] c_wr_clr  = 2'd2;
    localparam logic [1:0] c_rd      = 2'd3;

    logic [N-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_lw-1:0] r_level;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_clr_pend;
    logic            r_rb_due;
    logic [c_cw-1:0] r_rb_cnt;
    logic [N-1:0]    r_coe_R;
    logic            r_coe_R_valid;

    logic            w_push;
    logic            w_data_done;
    logic            w_clr_done;
    logic            w_rd_done;
    logic            w_select;
    logic [c_lw-1:0] w_level_nxt;
    logic            w_clr_nxt;
    logic            w_due_nxt;
    logic [c_cw-1:0] w_cnt_nxt;

    assign asi_in_ready = (r_level != c_lw'(DEPTH)) && !rsi_srst;
    assign w_push       = asi_in_valid && asi_in_ready;
    assign w_data_done  = (r_state == c_wr_data) && !avm_m0_waitrequest;
    assign w_clr_done   = (r_state == c_wr_clr)  && !avm_m0_waitrequest;
    assign w_rd_done    = (r_state == c_rd)      && !avm_m0_waitrequest;
    assign w_select     = (r_state == c_idle) || !avm_m0_waitrequest;
    assign w_level_nxt  = r_level + c_lw'(w_push) - c_lw'(w_data_done);

    // A clear arriving in the same cycle its predecessor completes is re-issued,
    // so every request is followed by at least one clear write.
    assign w_clr_nxt = (r_clr_pend && !w_clr_done) || coe_clear;

    always_comb begin
        w_cnt_nxt = r_rb_cnt;
        w_due_nxt = r_rb_due && !w_rd_done;
        if (w_data_done && (RB_EVERY != 0)) begin
            if (r_rb_cnt == c_rb_last) begin
                w_cnt_nxt = '0;
                w_due_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_rb_cnt + c_cw'(1);
            end
        end
    end

    // State register
    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection looks at post-update bookkeeping so the following
    // command is issued in the cycle right after a push or completion.
    always_comb begin
        w_state_nxt = r_state;
        if (w_select) begin
            if (w_due_nxt) begin
                w_state_nxt = c_rd;
            end else if (w_clr_nxt) begin
                w_state_nxt = c_wr_clr;
            end else if (w_level_nxt != '0) begin
                w_state_nxt = c_wr_data;
            end else begin
                w_state_nxt = c_idle;
            end
        end
    end

    // Bus outputs decode purely from state, so they stay stable under waitrequest.
    always_comb begin
        avm_m0_address   = 8'd0;
        avm_m0_write     = 1'b0;
        avm_m0_read      = 1'b0;
        avm_m0_writedata = '0;
        case (r_state)
            c_wr_data: begin
                avm_m0_address   = DATA_ADDR;
                avm_m0_write     = 1'b1;
                avm_m0_writedata = r_mem[r_rptr];
            end
            c_wr_clr: begin
                avm_m0_address = CLR_ADDR;
                avm_m0_write   = 1'b1;
            end
            c_rd: begin
                avm_m0_address = DATA_ADDR;
                avm_m0_read    = 1'b1;
            end
            default: begin
                avm_m0_address = 8'd0;
            end
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= asi_in_data;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_clr_pend    <= 1'b0;
            r_rb_due      <= 1'b0;
            r_rb_cnt      <= '0;
            r_coe_R       <= '0;
            r_coe_R_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_data_done) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            r_level       <= w_level_nxt;
            r_clr_pend    <= w_clr_nxt;
            r_rb_due      <= w_due_nxt;
            r_rb_cnt      <= w_cnt_nxt;
            r_coe_R_valid <= w_rd_done;
            if (w_rd_done) begin
                r_coe_R <= avm_m0_readdata;
            end
        end
    end

    assign coe_R       = r_coe_R;
    assign coe_R_valid = r_coe_R_valid;
    assign coe_level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_avm_integ_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_avm_integ_master
// Description : Directed bench with a queue-based reference model for the
//               integrator Avalon-MM master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avm_integ_master;

    localparam int         N         = 32;
    localparam int         DEPTH     = 4;
    localparam logic [7:0] DATA_ADDR = 8'd0;
    localparam logic [7:0] CLR_ADDR  = 8'd1;
    localparam int         RB_EVERY  = 4;

    logic         clk = 1'b0;
    logic         srst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         clear;
    logic [7:0]   address;
    logic         write;
    logic [N-1:0] writedata;
    logic         read;
    logic [N-1:0] readdata;
    logic         waitreq;
    logic [N-1:0] coe_r;
    logic         coe_r_valid;
    logic [2:0]   level;

    avm_integ_master #(
        .N(N), .DEPTH(DEPTH), .DATA_ADDR(DATA_ADDR), .CLR_ADDR(CLR_ADDR), .RB_EVERY(RB_EVERY)
    ) dut (
        .csi_clk            (clk),
        .rsi_srst           (srst),
        .asi_in_valid       (in_valid),
        .asi_in_ready       (in_ready),
        .asi_in_data        (in_data),
        .coe_clear          (clear),
        .avm_m0_address     (address),
        .avm_m0_write       (write),
        .avm_m0_writedata   (writedata),
        .avm_m0_read        (read),
        .avm_m0_readdata    (readdata),
        .avm_m0_waitrequest (waitreq),
        .coe_R              (coe_r),
        .coe_R_valid        (coe_r_valid),
        .coe_level          (level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int          mq[$];
    bit          m_clr;
    bit          m_due;
    int          m_cnt;
    logic [31:0] m_r;
    bit          m_rv;
    bit          armed = 1'b0;
    bit          prev_stall;
    logic [7:0]  p_addr;
    logic        p_wr;
    logic        p_rd;
    logic [31:0] p_wd;

    // Completion log and per-test counters
    byte         lk[$];
    int          ld[$];
    int          wr_cycles;
    int          rv_pulses;

    always @(negedge clk) begin
        if (srst) begin
            chk("ready_in_reset", 64'(in_ready), 64'd0);
            mq.delete();
            m_clr = 0; m_due = 0; m_cnt = 0; m_r = '0; m_rv = 0;
            prev_stall = 0;
            armed = 1'b1;
        end else if (armed) begin
            chk("level", 64'(level), 64'(mq.size()));
            chk("ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("wr_rd_excl", 64'(write && read), 64'd0);
            chk("coe_R", 64'(coe_r), 64'(m_r));
            chk("coe_R_valid", 64'(coe_r_valid), 64'(m_rv));
            if (prev_stall) begin
                chk("hold_addr", 64'(address), 64'(p_addr));
                chk("hold_write", 64'(write), 64'(p_wr));
                chk("hold_read", 64'(read), 64'(p_rd));
                chk("hold_wdata", 64'(writedata), 64'(p_wd));
            end else if (m_due) begin
                chk("cmd_read", 64'({write, read}), 64'b01);
                chk("rd_addr", 64'(address), 64'(DATA_ADDR));
            end else if (m_clr) begin
                chk("cmd_clr", 64'({write, read}), 64'b10);
                chk("clr_addr", 64'(address), 64'(CLR_ADDR));
                chk("clr_wdata", 64'(writedata), 64'd0);
            end else if (mq.size() > 0) begin
                chk("cmd_data", 64'({write, read}), 64'b10);
                chk("data_addr", 64'(address), 64'(DATA_ADDR));
                chk("data_wdata", 64'(writedata), 64'(mq[0]));
            end else begin
                chk("cmd_none", 64'({write, read}), 64'b00);
            end

            if (write) wr_cycles++;
            if (coe_r_valid) rv_pulses++;
            m_rv = 0;
            if (write && !waitreq) begin
                if (address == DATA_ADDR) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    m_cnt++;
                    if (m_cnt == RB_EVERY) begin
                        m_due = 1;
                        m_cnt = 0;
                    end
                    lk.push_back("D");
                end else begin
                    m_clr = 0;
                    lk.push_back("C");
                end
                ld.push_back(int'(writedata));
            end
            if (read && !waitreq) begin
                m_due = 0;
                m_r   = readdata;
                m_rv  = 1;
                lk.push_back("R");
                ld.push_back(int'(readdata));
            end
            if (in_valid && in_ready) mq.push_back(int'(in_data));
            if (clear) m_clr = 1;
            prev_stall = (write || read) && waitreq;
            p_addr = address; p_wr = write; p_rd = read; p_wd = writedata;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        lk.delete(); ld.delete();
        wr_cycles = 0; rv_pulses = 0;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = N'(v);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic push_wait(input int v);
        int b;
        in_valid = 1'b1;
        in_data  = N'(v);
        b = 0;
        while (!in_ready && b < 20) begin
            step(1);
            b++;
        end
        if (b == 20) chk("push_timeout", 64'd1, 64'd0);
        step(1);
        in_valid = 1'b0;
    endtask

    initial begin
        int dq[$];
        srst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        readdata = 32'd77; waitreq = 1'b0;
        step(2);
        srst = 1'b0;
        chk("reset_write", 64'(write), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_coe_R", 64'(coe_r), 64'd0);
        lk.delete(); ld.delete(); wr_cycles = 0; rv_pulses = 0;
        step(1);

        // 1: single sample, write one cycle after push
        push(55);
        chk("t1_write", 64'(write), 64'd1);
        chk("t1_addr", 64'(address), 64'd0);
        chk("t1_wdata", 64'(writedata), 64'd55);
        step(1);
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_ncomp", 64'(lk.size()), 64'd1);

        // 2: three stall cycles, stable four cycles, one completion
        do_reset();
        waitreq = 1'b1;
        push(32'hA5);
        step(3);
        waitreq = 1'b0;
        step(3);
        chk("t2_wr_cycles", 64'(wr_cycles), 64'd4);
        chk("t2_ncomp", 64'(lk.size()), 64'd1);
        if (ld.size() > 0) chk("t2_data", 64'(ld[0]), 64'hA5);

        // 3: overfill while stalled, then drain in order
        do_reset();
        waitreq = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h31 + i);
        in_valid = 1'b1; in_data = 32'h35;
        step(2);
        chk("t3_ready_full", 64'(in_ready), 64'd0);
        chk("t3_level_full", 64'(level), 64'd4);
        waitreq = 1'b0;
        push_wait(32'h35);
        push_wait(32'h36);
        step(12);
        dq.delete();
        for (int i = 0; i < lk.size(); i++) if (lk[i] == "D") dq.push_back(ld[i]);
        chk("t3_ndata", 64'(dq.size()), 64'd6);
        for (int i = 0; i < dq.size() && i < 6; i++) chk("t3_order", 64'(dq[i]), 64'(32'h31 + i));
        if (lk.size() > 4) chk("t3_read_after_4", 64'(lk[4]), 64'("R"));

        // 4: clear during a stalled data write
        do_reset();
        waitreq = 1'b1;
        push(1); push(2); push(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        waitreq = 1'b0;
        step(8);
        chk("t4_ncomp", 64'(lk.size()), 64'd4);
        if (lk.size() == 4) begin
            chk("t4_k0", 64'(lk[0]), 64'("D")); chk("t4_d0", 64'(ld[0]), 64'd1);
            chk("t4_k1", 64'(lk[1]), 64'("C")); chk("t4_d1", 64'(ld[1]), 64'd0);
            chk("t4_k2", 64'(lk[2]), 64'("D")); chk("t4_d2", 64'(ld[2]), 64'd2);
            chk("t4_k3", 64'(lk[3]), 64'("D")); chk("t4_d3", 64'(ld[3]), 64'd3);
        end

        // 5: readback after the fourth write
        do_reset();
        readdata = 32'd10;
        for (int i = 1; i <= 4; i++) push(i);
        step(6);
        chk("t5_ncomp", 64'(lk.size()), 64'd5);
        if (lk.size() == 5) chk("t5_read", 64'(lk[4]), 64'("R"));
        chk("t5_coe_R", 64'(coe_r), 64'd10);
        chk("t5_pulses", 64'(rv_pulses), 64'd1);

        // 6: reset during a stalled write drops everything
        waitreq = 1'b1;
        push(7);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        srst = 1'b1;
        step(1);
        chk("t6_write", 64'(write), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_coe_R", 64'(coe_r), 64'd0);
        srst = 1'b0;
        waitreq = 1'b0;
        wr_cycles = 0;
        step(6);
        chk("t6_no_writes", 64'(wr_cycles), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
